// File: rtl/traffic_phase_ctrl.sv
// Four-phase two-road traffic light sequencer with 1 s tick and BCD countdown digits.
// Optional night flashing mode guarded by TRAFFIC_NIGHT_FLASH_EN (adds input night).
module traffic_phase_ctrl #(
  parameter int unsigned G_TIME   = 25,
  parameter int unsigned Y_TIME   = 3,
  parameter int unsigned TICK_DIV = 500
) (
  input  logic       clk_500,
  input  logic       rst_n,
  input  logic       en,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [1:0] phase,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] fir,
  output logic [3:0] sec,
  output logic [3:0] thi,
  output logic [3:0] fou
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int unsigned GY_TIME = G_TIME + Y_TIME;
  localparam logic [7:0] G_BCD  = {4'(G_TIME / 10), 4'(G_TIME % 10)};
  localparam logic [7:0] Y_BCD  = {4'(Y_TIME / 10), 4'(Y_TIME % 10)};
  localparam logic [7:0] GY_BCD = {4'(GY_TIME / 10), 4'(GY_TIME % 10)};
  localparam logic [7:0] ONE_BCD = 8'h01;

  typedef enum logic [2:0] {
    ST_NS_G  = 3'd0,
    ST_NS_Y  = 3'd1,
    ST_EW_G  = 3'd2,
    ST_EW_Y  = 3'd3
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ,ST_FLASH = 3'd4
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [7:0]    ns_cnt, ns_cnt_nxt;
  logic [7:0]    ew_cnt, ew_cnt_nxt;
  logic [1:0]    phase_nxt;
  logic [2:0]    ns_light_nxt, ew_light_nxt;
  logic          tick;
  logic [7:0]    ns_dec, ew_dec;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic          flash_on, flash_on_nxt;
`endif

  // Two-digit BCD decrement; callers never let a counter reach 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign ns_dec = bcd_dec(ns_cnt);
  assign ew_dec = bcd_dec(ew_cnt);
  assign tick   = en && (tick_cnt == TICK_LAST);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    ns_cnt_nxt   = ns_cnt;
    ew_cnt_nxt   = ew_cnt;
    phase_nxt    = 2'd0;
    ns_light_nxt = 3'b001;
    ew_light_nxt = 3'b100;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    flash_on_nxt = flash_on;
`endif

    if (en) begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + TW'(1);
    end

    // Sequencing: the green/yellow road's counter governs the phase change.
    if (tick) begin
      case (state)
        ST_NS_G: begin
          ew_cnt_nxt = ew_dec;
          if (ns_cnt == ONE_BCD) begin
            state_nxt  = ST_NS_Y;
            ns_cnt_nxt = Y_BCD;
          end else begin
            ns_cnt_nxt = ns_dec;
          end
        end
        ST_NS_Y: begin
          if (ns_cnt == ONE_BCD) begin
            state_nxt  = ST_EW_G;
            ns_cnt_nxt = GY_BCD;
            ew_cnt_nxt = G_BCD;
          end else begin
            ns_cnt_nxt = ns_dec;
            ew_cnt_nxt = ew_dec;
          end
        end
        ST_EW_G: begin
          ns_cnt_nxt = ns_dec;
          if (ew_cnt == ONE_BCD) begin
            state_nxt  = ST_EW_Y;
            ew_cnt_nxt = Y_BCD;
          end else begin
            ew_cnt_nxt = ew_dec;
          end
        end
        ST_EW_Y: begin
          if (ew_cnt == ONE_BCD) begin
            state_nxt  = ST_NS_G;
            ns_cnt_nxt = G_BCD;
            ew_cnt_nxt = GY_BCD;
          end else begin
            ns_cnt_nxt = ns_dec;
            ew_cnt_nxt = ew_dec;
          end
        end
`ifdef TRAFFIC_NIGHT_FLASH_EN
        ST_FLASH: begin
          if (!night) begin
            state_nxt    = ST_NS_G;
            ns_cnt_nxt   = G_BCD;
            ew_cnt_nxt   = GY_BCD;
            flash_on_nxt = 1'b0;
          end else begin
            flash_on_nxt = ~flash_on;
          end
        end
`endif
        default: begin
          state_nxt  = ST_NS_G;
          ns_cnt_nxt = G_BCD;
          ew_cnt_nxt = GY_BCD;
        end
      endcase
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night request restarts the 1 s timebase so the first flash lasts a full second.
    if (en && night && (state != ST_FLASH)) begin
      state_nxt    = ST_FLASH;
      tick_cnt_nxt = '0;
      ns_cnt_nxt   = 8'hFF;
      ew_cnt_nxt   = 8'hFF;
      flash_on_nxt = 1'b1;
    end
`endif

    case (state_nxt)
      ST_NS_G: begin phase_nxt = 2'd0; ns_light_nxt = 3'b001; ew_light_nxt = 3'b100; end
      ST_NS_Y: begin phase_nxt = 2'd1; ns_light_nxt = 3'b010; ew_light_nxt = 3'b100; end
      ST_EW_G: begin phase_nxt = 2'd2; ns_light_nxt = 3'b100; ew_light_nxt = 3'b001; end
      ST_EW_Y: begin phase_nxt = 2'd3; ns_light_nxt = 3'b100; ew_light_nxt = 3'b010; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH: begin
        phase_nxt    = 2'd0;
        ns_light_nxt = flash_on_nxt ? 3'b010 : 3'b000;
        ew_light_nxt = flash_on_nxt ? 3'b010 : 3'b000;
      end
`endif
      default: begin phase_nxt = 2'd0; ns_light_nxt = 3'b001; ew_light_nxt = 3'b100; end
    endcase
  end

  always_ff @(posedge clk_500) begin
    if (!rst_n) begin
      state    <= ST_NS_G;
      tick_cnt <= '0;
      ns_cnt   <= G_BCD;
      ew_cnt   <= GY_BCD;
      phase    <= 2'd0;
      ns_light <= 3'b001;
      ew_light <= 3'b100;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_on <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      ns_cnt   <= ns_cnt_nxt;
      ew_cnt   <= ew_cnt_nxt;
      phase    <= phase_nxt;
      ns_light <= ns_light_nxt;
      ew_light <= ew_light_nxt;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_on <= flash_on_nxt;
`endif
    end
  end

  assign fir = ns_cnt[7:4];
  assign sec = ns_cnt[3:0];
  assign thi = ew_cnt[7:4];
  assign fou = ew_cnt[3:0];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench: two sequencer instances (G=5/Y=3 and G=12/Y=3, TICK_DIV=4)
// against a reference model based on elapsed seconds within the light cycle.
module tb_traffic_phase_ctrl;

  localparam int unsigned TD = 4;

  logic clk_500 = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic night   = 1'b0;

  logic [1:0] a_phase, b_phase;
  logic [2:0] a_ns, a_ew, b_ns, b_ew;
  logic [3:0] a_fir, a_sec, a_thi, a_fou, b_fir, b_sec, b_thi, b_fou;

  int compared = 0;
  int mismatched = 0;

  int g_t[2] = '{5, 12};
  int y_t[2] = '{3, 3};
  int m_cnt[2];
  int m_t[2];
  bit m_fl[2];
  bit m_lamp[2];

  always #5 clk_500 = ~clk_500;

  traffic_phase_ctrl #(.G_TIME(5), .Y_TIME(3), .TICK_DIV(TD)) u_a (
    .clk_500(clk_500), .rst_n(rst_n), .en(en),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .phase(a_phase), .ns_light(a_ns), .ew_light(a_ew),
    .fir(a_fir), .sec(a_sec), .thi(a_thi), .fou(a_fou)
  );

  traffic_phase_ctrl #(.G_TIME(12), .Y_TIME(3), .TICK_DIV(TD)) u_b (
    .clk_500(clk_500), .rst_n(rst_n), .en(en),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .phase(b_phase), .ns_light(b_ns), .ew_light(b_ew),
    .fir(b_fir), .sec(b_sec), .thi(b_thi), .fou(b_fou)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model advance for one clock edge, using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_t[i] = 0; m_fl[i] = 0; m_lamp[i] = 0;
      end else if (en) begin
        if (night && !m_fl[i]) begin
          m_fl[i] = 1; m_lamp[i] = 1; m_cnt[i] = 0;
        end else if (m_cnt[i] == TD - 1) begin
          m_cnt[i] = 0;
          if (m_fl[i]) begin
            if (!night) begin m_fl[i] = 0; m_t[i] = 0; end
            else m_lamp[i] = !m_lamp[i];
          end else begin
            m_t[i] = (m_t[i] + 1) % (2 * (g_t[i] + y_t[i]));
          end
        end else begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic exp_vals(input int i, output logic [1:0] ph, output logic [2:0] nl,
                          output logic [2:0] el, output logic [15:0] dg);
    int g, y, t, ns, ew;
    g = g_t[i]; y = y_t[i]; t = m_t[i];
    if (m_fl[i]) begin
      ph = 2'd0; nl = m_lamp[i] ? 3'b010 : 3'b000; el = nl; dg = 16'hFFFF;
    end else begin
      if (t < g) begin
        ph = 2'd0; nl = 3'b001; el = 3'b100; ns = g - t; ew = g + y - t;
      end else if (t < g + y) begin
        ph = 2'd1; nl = 3'b010; el = 3'b100; ns = g + y - t; ew = g + y - t;
      end else if (t < 2 * g + y) begin
        ph = 2'd2; nl = 3'b100; el = 3'b001; ns = 2 * (g + y) - t; ew = 2 * g + y - t;
      end else begin
        ph = 2'd3; nl = 3'b100; el = 3'b010; ns = 2 * (g + y) - t; ew = ns;
      end
      dg = {4'(ns / 10), 4'(ns % 10), 4'(ew / 10), 4'(ew % 10)};
    end
  endtask

  task automatic check_all();
    logic [1:0] ph; logic [2:0] nl, el; logic [15:0] dg;
    exp_vals(0, ph, nl, el, dg);
    chk("a_phase", 16'(a_phase), 16'(ph));
    chk("a_lamps", {10'd0, a_ns, a_ew}, {10'd0, nl, el});
    chk("a_digits", {a_fir, a_sec, a_thi, a_fou}, dg);
    exp_vals(1, ph, nl, el, dg);
    chk("b_phase", 16'(b_phase), 16'(ph));
    chk("b_lamps", {10'd0, b_ns, b_ew}, {10'd0, nl, el});
    chk("b_digits", {b_fir, b_sec, b_thi, b_fou}, dg);
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk_500);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    // Reset held over three edges
    rst_n = 1'b0; en = 1'b1;
    clk_n(3);
    chk("rst_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0508);
    chk("rst_lamps", {10'd0, a_ns, a_ew}, {10'd0, 3'b001, 3'b100});

    // Phase advance
    rst_n = 1'b1;
    clk_n(16);
    chk("four_ticks", {a_fir, a_sec, a_thi, a_fou}, 16'h0104);
    clk_n(4);
    chk("enter_nsy_phase", 16'(a_phase), 16'd1);
    chk("enter_nsy_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0303);
    chk("enter_nsy_lamps", {10'd0, a_ns, a_ew}, {10'd0, 3'b010, 3'b100});

    // BCD borrow on the G=12 instance
    clk_n(4);
    chk("borrow_digits", {b_fir, b_sec, b_thi, b_fou}, 16'h0609);

    // EW green, then full-cycle wrap
    clk_n(8);
    chk("ewg_phase", 16'(a_phase), 16'd2);
    chk("ewg_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0805);
    chk("ewg_lamps", {10'd0, a_ns, a_ew}, {10'd0, 3'b100, 3'b001});
    clk_n(32);
    chk("wrap_phase", 16'(a_phase), 16'd0);
    chk("wrap_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0508);

    // Freeze mid EW green, then resume
    for (int k = 0; k < 200 && a_phase != 2'd2; k++) clk_n(1);
    chk("wait_phase2", 16'(a_phase), 16'd2);
    clk_n(2);
    en = 1'b0;
    clk_n(100);
    en = 1'b1;
    clk_n(10);

    // Reset for a single edge in EW yellow
    for (int k = 0; k < 200 && a_phase != 2'd3; k++) clk_n(1);
    chk("wait_phase3", 16'(a_phase), 16'd3);
    rst_n = 1'b0;
    clk_n(1);
    rst_n = 1'b1;
    chk("midrst_phase", 16'(a_phase), 16'd0);
    chk("midrst_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0508);
    clk_n(9);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    for (int k = 0; k < 200 && a_phase != 2'd1; k++) clk_n(1);
    chk("wait_phase1", 16'(a_phase), 16'd1);
    night = 1'b1;
    clk_n(1);
    chk("flash_digits", {a_fir, a_sec, a_thi, a_fou}, 16'hFFFF);
    chk("flash_lamps_on", {10'd0, a_ns, a_ew}, {10'd0, 3'b010, 3'b010});
    clk_n(4);
    chk("flash_lamps_off", {10'd0, a_ns, a_ew}, 16'd0);
    clk_n(4);
    chk("flash_lamps_on2", {10'd0, a_ns, a_ew}, {10'd0, 3'b010, 3'b010});
    night = 1'b0;
    clk_n(4);
    chk("flash_exit_phase", 16'(a_phase), 16'd0);
    chk("flash_exit_digits", {a_fir, a_sec, a_thi, a_fou}, 16'h0508);
`endif

    // Randomized enable, sparse resets and night bursts
    for (int k = 0; k < 1500; k++) begin
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
`ifdef TRAFFIC_NIGHT_FLASH_EN
      if ($urandom_range(0, 99) == 0) night = ~night;
`endif
      clk_n(1);
    end
    rst_n = 1'b1; en = 1'b1; night = 1'b0;
    clk_n(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
